// File: rtl/transmisor_uart_if.sv
// Host-side byte handshake of the UART transmitter: write strobe, data,
// parity mode and the transmit-data-register-empty flag.
interface transmisor_uart_if;
   logic [7:0] tx_data;
   logic       tdre_clr;
   logic [1:0] parity;
   logic       tdre;

   // Handshake: the host may pulse tdre_clr for one cycle only while tdre=1;
   // that edge latches tx_data and drops tdre. A strobe seen while tdre=0 is
   // discarded. tdre returns to 1 when the byte moves into the shift register.
   modport master (output tx_data, output tdre_clr, output parity, input tdre);
   modport slave  (input tx_data, input tdre_clr, input parity, output tdre);
endinterface

// File: rtl/transmisor_uart.sv
// Double-buffered UART transmitter: start, 8 data bits LSB first, optional
// even/odd parity, one stop bit. TxD and busy are registered outputs.
module transmisor_uart #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                clk,
   input  logic                reset,
   transmisor_uart_if.slave    bus,
   output logic                TxD,
   output logic                busy,
   output logic [2:0]          state_dbg
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    hold;
   logic          tdre_r;
   logic [7:0]    shift;
   logic [7:0]    shift_d;
   logic          par_en;
   logic          par_bit;
   logic          txd_d;
   logic          busy_d;
   logic          bit_end;
   logic          transfer;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign transfer  = !tdre_r && ((state == IDLE) || (state == STOP && bit_end));
   assign bus.tdre  = tdre_r;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (transfer) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && bit_cnt == 3'd7) state_next = par_en ? PARITY : STOP;
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (bit_end) state_next = transfer ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // TxD is loaded from the value the line must carry in the upcoming state,
   // so the start bit appears on the same edge as the transfer.
   always_comb begin
      shift_d = shift;
      if (transfer)                     shift_d = hold;
      else if (state == DATA && bit_end) shift_d = {1'b0, shift[7:1]};
      case (state_next)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_bit;
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_next != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         hold     <= '0;
         tdre_r   <= 1'b1;
         shift    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         TxD      <= 1'b1;
         busy     <= 1'b0;
      end else begin
         if (state_next != state || bit_end) baud_cnt <= '0;
         else if (state != IDLE)             baud_cnt <= baud_cnt + 1'b1;

         if (state_next != state)           bit_cnt <= '0;
         else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;

         // A strobe coinciding with a transfer sees tdre=0 and is dropped.
         if (transfer) begin
            tdre_r  <= 1'b1;
            par_en  <= (bus.parity == 2'b01) || (bus.parity == 2'b10);
            par_bit <= (^hold) ^ (bus.parity == 2'b10);
         end else if (bus.tdre_clr && tdre_r) begin
            hold   <= bus.tx_data;
            tdre_r <= 1'b0;
         end

         shift <= shift_d;
         TxD   <= txd_d;
         busy  <= busy_d;
      end
   end

endmodule

// File: tb/tb_transmisor_uart.sv
// Directed bench for transmisor_uart: vector table of single frames plus
// hand-written back-to-back, overrun, mode-change and mid-frame reset cases.
module tb_transmisor_uart;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       TxD;
   logic       busy;
   logic [2:0] state_dbg;

   transmisor_uart_if bus();

   transmisor_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .TxD       (TxD),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   int         total = 0;
   int         passed = 0;
   logic [1:0] exp_q[$];   // per-cycle expected {busy, TxD}
   vec_t       vecs[7];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   function automatic void push_frame(input logic [7:0] d, input logic pen, input logic pb);
      logic fb[11];
      int   nb;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[i+1] = d[i];
      if (pen) begin
         fb[9]  = pb;
         fb[10] = 1'b1;
         nb     = 11;
      end else begin
         fb[9]  = 1'b1;
         fb[10] = 1'b1;
         nb     = 10;
      end
      for (int b = 0; b < nb; b++)
         for (int c = 0; c < CPB; c++) exp_q.push_back({1'b1, fb[b]});
   endfunction

   task automatic drain();
      logic [1:0] e;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("line", {6'b0, busy, TxD}, {6'b0, e});
      end
   endtask

   task automatic strobe(input logic [7:0] d);
      @(negedge clk);
      bus.tx_data  = d;
      bus.tdre_clr = 1'b1;
      @(negedge clk);
      bus.tdre_clr = 1'b0;
   endtask

   initial begin
      logic [1:0] e;
      vecs[0] = '{8'hA5, 2'b00, 1'b0, 40};
      vecs[1] = '{8'hA5, 2'b01, 1'b0, 44};
      vecs[2] = '{8'hA5, 2'b10, 1'b1, 44};
      vecs[3] = '{8'h07, 2'b01, 1'b1, 44};
      vecs[4] = '{8'h07, 2'b11, 1'b0, 40};
      vecs[5] = '{8'h00, 2'b10, 1'b1, 44};
      vecs[6] = '{8'hFF, 2'b01, 1'b0, 44};

      bus.tx_data  = 8'h00;
      bus.tdre_clr = 1'b0;
      bus.parity   = 2'b00;

      // Reset held, then idle line
      repeat (5) begin
         @(negedge clk);
         chk("reset_out", {5'b0, TxD, bus.tdre, busy}, 8'b110);
      end
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk("idle_out", {5'b0, TxD, bus.tdre, busy}, 8'b110);
      end
      chk("idle_state", {5'b0, state_dbg}, 8'd0);

      // Single frames from the vector table
      for (int v = 0; v < 7; v++) begin
         bus.parity = vecs[v].mode;
         push_frame(vecs[v].data, vecs[v].exp_len == 44, vecs[v].exp_par);
         exp_q.push_back(2'b01);
         strobe(vecs[v].data);
         chk("tdre_after_strobe", {7'b0, bus.tdre}, 8'd0);
         @(negedge clk);
         e = exp_q.pop_front();
         chk("start_bit", {6'b0, busy, TxD}, {6'b0, e});
         chk("tdre_released", {7'b0, bus.tdre}, 8'd1);
         drain();
      end

      // Back-to-back 0x41/0x42 with an overrunning 0xFF strobe
      bus.parity = 2'b00;
      push_frame(8'h41, 1'b0, 1'b0);
      push_frame(8'h42, 1'b0, 1'b0);
      exp_q.push_back(2'b01);
      strobe(8'h41);
      chk("b2b_tdre0", {7'b0, bus.tdre}, 8'd0);
      fork
         drain();
         begin
            repeat (11) @(negedge clk);
            strobe(8'h42);
            chk("b2b_second_held", {7'b0, bus.tdre}, 8'd0);
            strobe(8'hFF);
            chk("overrun_tdre", {7'b0, bus.tdre}, 8'd0);
            repeat (25) @(negedge clk);
            chk("tdre_last_stop", {7'b0, bus.tdre}, 8'd0);
            @(negedge clk);
            chk("tdre_boundary", {7'b0, bus.tdre}, 8'd1);
         end
      join
      repeat (3) begin
         @(negedge clk);
         chk("no_third_frame", {6'b0, busy, TxD}, 8'b01);
      end

      // Parity mode changed mid-frame keeps the latched even parity
      bus.parity = 2'b01;
      push_frame(8'hA5, 1'b1, 1'b0);
      exp_q.push_back(2'b01);
      strobe(8'hA5);
      fork
         drain();
         begin
            repeat (6) @(negedge clk);
            bus.parity  = 2'b00;
            bus.tx_data = 8'h00;
         end
      join

      // Reset during data bit 3 with a byte held
      strobe(8'hA5);
      repeat (10) @(negedge clk);
      strobe(8'h5A);
      chk("held_before_reset", {7'b0, bus.tdre}, 8'd0);
      repeat (6) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_out", {5'b0, TxD, bus.tdre, busy}, 8'b110);
      chk("async_reset_state", {5'b0, state_dbg}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {5'b0, TxD, bus.tdre, busy}, 8'b110);
      push_frame(8'h3C, 1'b0, 1'b0);
      exp_q.push_back(2'b01);
      strobe(8'h3C);
      chk("post_reset_tdre", {7'b0, bus.tdre}, 8'd0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
